// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Register-file write-port arbiter (WB vs long-latency unit) with
//            pending-result scoreboard and decode RAW/WAW hazard stall.
//            Optional macro REGFILE_WB_STARVE_GUARD_EN enables the LLU
//            starvation counter and forced grant.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        llu_issue_valid,
    input  logic [4:0]  llu_issue_rd,
    output logic        llu_issue_ready,
    input  logic        llu_res_valid,
    input  logic [4:0]  llu_res_rd,
    input  logic [31:0] llu_res_data,
    output logic        llu_res_ready,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_we,
    output logic        hazard_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
            $error("STARVE_LIMIT must be in 1..7");
        end
    endgenerate

    logic [31:0] r_pending;
    logic [31:0] w_pending_nxt;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic        r_from_llu;
    logic        w_forced;
    logic        w_wb_grant;
    logic        w_llu_grant;
    logic        w_launch;
    logic [4:0]  w_wr_rd;
    logic [31:0] w_wr_data;

`ifdef REGFILE_WB_STARVE_GUARD_EN
    localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);
    logic [2:0] r_starve_cnt;

    // Forcing only makes sense while a result is actually waiting.
    assign w_forced = llu_res_valid && (r_starve_cnt == c_starve_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 3'd0;
        end else if (!llu_res_valid || w_llu_grant) begin
            r_starve_cnt <= 3'd0;
        end else if (r_starve_cnt != c_starve_limit) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
    end
`else
    assign w_forced = 1'b0;
`endif

    assign w_wb_grant  = wb_valid && !w_forced;
    assign w_llu_grant = llu_res_valid && (!wb_valid || w_forced);
    assign wb_stall      = wb_valid && w_forced;
    assign llu_res_ready = w_llu_grant;

    assign llu_issue_ready = !r_pending[llu_issue_rd] || (llu_issue_rd == 5'd0);
    assign w_launch = llu_issue_valid && llu_issue_ready && (llu_issue_rd != 5'd0);

    assign w_wr_rd   = w_llu_grant ? llu_res_rd   : wb_rd;
    assign w_wr_data = w_llu_grant ? llu_res_data : wb_data;

    // Clear applied before set so a same-edge launch to the same register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_rf_we && r_from_llu) begin
            w_pending_nxt[r_rf_waddr] = 1'b0;
        end
        if (w_launch) begin
            w_pending_nxt[llu_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= 32'd0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
            r_from_llu <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_rf_we    <= (w_wb_grant || w_llu_grant) && (w_wr_rd != 5'd0);
            r_from_llu <= w_llu_grant;
            if (w_wb_grant || w_llu_grant) begin
                r_rf_waddr <= w_wr_rd;
                r_rf_wdata <= w_wr_data;
            end
        end
    end

    assign hazard_stall = (id_use_rs && r_pending[id_rs]) ||
                          (id_use_rt && r_pending[id_rt]) ||
                          (id_we     && r_pending[id_rd]);

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Directed, table-driven bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        wb_stall;
    logic        llu_issue_valid = 1'b0;
    logic [4:0]  llu_issue_rd = 5'd0;
    logic        llu_issue_ready;
    logic        llu_res_valid = 1'b0;
    logic [4:0]  llu_res_rd = 5'd0;
    logic [31:0] llu_res_data = 32'd0;
    logic        llu_res_ready;
    logic [4:0]  id_rs = 5'd0;
    logic [4:0]  id_rt = 5'd0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic [4:0]  id_rd = 5'd0;
    logic        id_we = 1'b0;
    logic        hazard_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
        .llu_issue_valid(llu_issue_valid), .llu_issue_rd(llu_issue_rd),
        .llu_issue_ready(llu_issue_ready),
        .llu_res_valid(llu_res_valid), .llu_res_rd(llu_res_rd),
        .llu_res_data(llu_res_data), .llu_res_ready(llu_res_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_we(id_we), .hazard_stall(hazard_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus; ir/rr/ws/hz checked mid-cycle, we/wa/wd after the edge.
    typedef struct {
        int rst, wbv, wbrd, wbd;
        int iv, ird;
        int rv, rrd, rdat;
        int rs, urs, rt, urt, idrd, idwe;
        int ir, rr, ws, hz;
        int we, ck, wa, wd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset           = (v.rst != 0);
        wb_valid        = (v.wbv != 0);
        wb_rd           = 5'(v.wbrd);
        wb_data         = v.wbd;
        llu_issue_valid = (v.iv != 0);
        llu_issue_rd    = 5'(v.ird);
        llu_res_valid   = (v.rv != 0);
        llu_res_rd      = 5'(v.rrd);
        llu_res_data    = v.rdat;
        id_rs           = 5'(v.rs);
        id_use_rs       = (v.urs != 0);
        id_rt           = 5'(v.rt);
        id_use_rt       = (v.urt != 0);
        id_rd           = 5'(v.idrd);
        id_we           = (v.idwe != 0);
        #1;
        chk({tag, " issue_ready"},  32'(llu_issue_ready), v.ir);
        chk({tag, " res_ready"},    32'(llu_res_ready),   v.rr);
        chk({tag, " wb_stall"},     32'(wb_stall),        v.ws);
        chk({tag, " hazard_stall"}, 32'(hazard_stall),    v.hz);
        @(posedge clk);
        #1;
        chk({tag, " rf_we"}, 32'(rf_we), v.we);
        if (v.ck != 0) begin
            chk({tag, " rf_waddr"}, 32'(rf_waddr), v.wa);
            chk({tag, " rf_wdata"}, rf_wdata, v.wd);
        end
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{0,0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0, 1,0,0,0, 0,0,0,0};
        return v;
    endfunction

    initial begin
        vec_t v;
        int   k;
        //        rst wbv wbrd wbd       iv ird  rv rrd rdat       rs urs rt urt idrd idwe  ir rr ws hz  we ck wa wd
        tbl.push_back('{1,0,0,0,          0,0,   0,0,0,          0,0,0,0,0,0,     1,0,0,0, 0,1,0,0});
        tbl.push_back('{0,1,5,'h1234,     0,0,   0,0,0,          0,0,0,0,0,0,     1,0,0,0, 1,1,5,'h1234});
        tbl.push_back('{0,0,0,0,          1,8,   0,0,0,          0,0,0,0,0,0,     1,0,0,0, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          1,8,   0,0,0,          8,1,0,0,0,0,     0,0,0,1, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          1,0,   0,0,0,          0,0,8,1,0,0,     1,0,0,1, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          0,0,   0,0,0,          8,0,0,0,8,1,     1,0,0,1, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          0,0,   0,0,0,          0,1,0,0,0,1,     1,0,0,0, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          0,0,   1,8,'hBEEF,     8,1,0,0,0,0,     1,1,0,1, 1,1,8,'hBEEF});
        tbl.push_back('{0,0,0,0,          1,8,   0,0,0,          8,1,0,0,0,0,     0,0,0,1, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          0,8,   0,0,0,          8,1,0,0,0,0,     1,0,0,0, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          0,0,   1,0,'h5555,     0,0,0,0,0,0,     1,1,0,0, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          1,9,   0,0,0,          0,0,0,0,0,0,     1,0,0,0, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          1,10,  0,0,0,          9,1,0,0,0,0,     1,0,0,1, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          0,0,   1,9,'h99,       0,0,0,0,0,0,     1,1,0,0, 1,1,9,'h99});
        tbl.push_back('{0,0,0,0,          0,0,   1,10,'hAA,      10,1,0,0,0,0,    1,1,0,1, 1,1,10,'hAA});
        tbl.push_back('{0,0,0,0,          0,0,   0,0,0,          9,1,10,1,0,0,    1,0,0,1, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          0,0,   0,0,0,          0,0,10,1,0,0,    1,0,0,0, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          1,11,  0,0,0,          0,0,0,0,0,0,     1,0,0,0, 0,0,0,0});
        tbl.push_back('{0,1,6,'h66,       0,0,   1,11,'hB1,      0,0,0,0,0,0,     1,0,0,0, 1,1,6,'h66});
        tbl.push_back('{0,0,0,0,          0,0,   1,11,'hB1,      11,1,0,0,0,0,    1,1,0,1, 1,1,11,'hB1});
        tbl.push_back('{0,0,0,0,          0,0,   0,0,0,          11,1,0,0,0,0,    1,0,0,1, 0,0,0,0});
        tbl.push_back('{0,0,0,0,          0,0,   0,0,0,          11,1,0,0,0,0,    1,0,0,0, 0,0,0,0});
        tbl.push_back('{0,1,0,'h77,       0,0,   0,0,0,          0,0,0,0,0,0,     1,0,0,0, 0,0,0,0});

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Starvation: WB held busy while an LLU result for r12 waits.
        v = idle(); v.iv = 1; v.ird = 12;
        apply(v, "starve_launch");
`ifdef REGFILE_WB_STARVE_GUARD_EN
        k = 4;
`else
        k = 8;
`endif
        for (int i = 0; i < k; i++) begin
            v = idle();
            v.wbv = 1; v.wbrd = 7; v.wbd = 'h100 + i;
            v.rv = 1; v.rrd = 12; v.rdat = 'hC0DE;
            v.rs = 12; v.urs = 1; v.hz = 1;
            v.we = 1; v.ck = 1; v.wa = 7; v.wd = 'h100 + i;
            apply(v, $sformatf("starve_wait%0d", i));
        end
        v = idle();
        v.rv = 1; v.rrd = 12; v.rdat = 'hC0DE; v.rr = 1;
        v.rs = 12; v.urs = 1; v.hz = 1;
        v.we = 1; v.ck = 1; v.wa = 12; v.wd = 'hC0DE;
`ifdef REGFILE_WB_STARVE_GUARD_EN
        v.wbv = 1; v.wbrd = 7; v.wbd = 'h1FF; v.ws = 1;
`endif
        apply(v, "starve_grant");
        v = idle();
        v.wbv = 1; v.wbrd = 7; v.wbd = 'h1FF;
        v.rs = 12; v.urs = 1; v.hz = 1;
        v.we = 1; v.ck = 1; v.wa = 7; v.wd = 'h1FF;
        apply(v, "starve_after");
        v = idle(); v.rs = 12; v.urs = 1;
        apply(v, "starve_clear");

        // Reset while r3 is pending and its result is waiting behind WB.
        v = idle(); v.iv = 1; v.ird = 3;
        apply(v, "rst_launch");
        v = idle();
        v.rst = 1; v.wbv = 1; v.wbrd = 4; v.wbd = 'h44;
        v.rv = 1; v.rrd = 3; v.rdat = 'h33;
        v.rs = 3; v.urs = 1; v.hz = 1;
        v.ck = 1;
        apply(v, "rst_mid");
        v = idle(); v.rs = 3; v.urs = 1; v.ird = 3;
        apply(v, "rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file in the 5-stage pipeline. It shares the single register-file write port between the pipeline write-back stage and a long-latency unit (multiply/divide) that returns results out of band. It tracks registers with outstanding long-latency results and raises decode stalls on RAW/WAW hazards against them. It sits between MEM/WB, the long-latency unit and the register-file write port.

## Interface
- STARVE_LIMIT, 4, cycles a valid LLU result may be refused before it is forced through (1..7)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  WB stage holds a register write this cycle
- wb_rd  in  5  WB destination register
- wb_data  in  32  WB write data
- wb_stall  out  1  WB write refused this cycle; pipeline holds WB and all earlier stages
- llu_issue_valid  in  1  LLU op launched from decode
- llu_issue_rd  in  5  destination of launched op
- llu_issue_ready  out  1  launch accepted
- llu_res_valid  in  1  LLU result available
- llu_res_rd  in  5  result destination
- llu_res_data  in  32  result data
- llu_res_ready  out  1  result granted the write port this cycle
- id_rs, id_rt  in  5 each  decode source registers
- id_use_rs, id_use_rt  in  1 each  source actually read
- id_rd  in  5  decode destination; id_we  in  1  decode instruction writes id_rd
- hazard_stall  out  1  decode must stall
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  write address (registered)
- rf_wdata  out  32  write data (registered)

## Operation
- Scoreboard: 32-bit pending mask, bit 0 hard-wired 0.
- Launch: llu_issue_ready = !pending[llu_issue_rd] || llu_issue_rd==0. On valid&&ready with rd!=0, pending[rd] set at the edge.
- Arbitration (combinational, per cycle): default WB priority. WB granted if wb_valid and not forced; LLU granted (llu_res_ready=1) if llu_res_valid and (!wb_valid or forced).
- Starvation counter (3 bits): increments each cycle llu_res_valid && !llu_res_ready, saturating at STARVE_LIMIT; cleared when the LLU is granted or llu_res_valid=0. forced = (count==STARVE_LIMIT). When forced && wb_valid: wb_stall=1, LLU granted.
- Write stage: granted request registered into rf_we/rf_waddr/rf_wdata at the edge; rf_we=0 if no grant or granted rd==0. An internal from_llu flag registers alongside.
- Clear: at the edge ending a cycle with rf_we && from_llu, pending[rf_waddr] cleared (same edge the register file commits).
- hazard_stall = (id_use_rs && pending[id_rs]) || (id_use_rt && pending[id_rt]) || (id_we && pending[id_rd]); reg 0 never stalls.
- Launch setting and write clearing the same bit in one edge cannot occur (launch blocked while pending); if it does, set wins.

## Timing
- Reset values: pending=0, counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, from_llu=0. Combinational outputs follow from cleared state (llu_issue_ready=1, hazard_stall=0, wb_stall=0).
- Reset mid-operation: all pending results discarded; LLU is reset by the same signal.
- Latency: grant in cycle N -> rf_we high in N+1 -> register-file commit and pending clear at end of N+1 -> hazard_stall drops and decode reads new value in N+2.
- wb_stall is never asserted when wb_valid=0.
- Back-to-back LLU results with WB idle: one write per cycle, no bubble.

## Configuration
- REGFILE_WB_STARVE_GUARD_EN defined: starvation counter and forced grant as above.
- Undefined: strict WB priority; counter removed; wb_stall tied 0; LLU waits indefinitely while wb_valid=1.

## Test plan
- Reset, then wb_valid=1, wb_rd=5, wb_data=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; wb_stall=0.
- Launch rd=8, then decode id_rs=8, id_use_rs=1 -> hazard_stall=1 until LLU result (rd=8, 0xBEEF) granted in N; rf_we at N+1; hazard_stall=0 in N+2.
- Second launch to rd=8 while pending -> llu_issue_ready=0; launch with rd=0 -> accepted, no pending bit, no write when result returns.
- GUARD_EN, STARVE_LIMIT=4, wb_valid held 1, LLU result valid -> refused 4 cycles, 5th cycle llu_res_ready=1 and wb_stall=1 for exactly one cycle, then WB writes.
- Same stimulus without macro -> llu_res_ready stays 0, wb_stall stays 0 while wb_valid=1.
- Assert reset with pending[3]=1 and LLU result waiting -> next cycle pending=0, rf_we=0, hazard_stall=0 for id_rs=3.
